disp_scan: RTL and testbench
============================

DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 SHALL have parameter PRESCALE, default 1000: clk cycles per digit scan slot, legal range 2..65535.
REQ-002 SHALL have parameter BLINK_FRAMES, default 64: full 4-digit scan frames per blink half-period, legal range 1..255.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port key_valid, input, 1: one-cycle strobe indicating a new entered digit.
REQ-006 SHALL have port key_code, input, 4: hex value of the entered digit, sampled when key_valid=1.
REQ-007 SHALL have port clr, input, 1: level input; clears the entry buffer while high.
REQ-008 SHALL have port blink, input, 1: level input; when high, the display flashes.
REQ-009 SHALL have port digit_val, output, 4: value of the currently scanned digit, driving the downstream 7-segment decoder value input.
REQ-010 SHALL have port digit_en, output, 1: blank control, driving the decoder enable (0 = segments off).
REQ-011 SHALL have port digit_sel, output, 4: one-hot, active-high digit select.
REQ-012 SHALL have port count, output, 3: number of digits entered, 0..4.
REQ-013 SHALL have port code, output, 16: entered digits; the most recent digit is in [3:0].

Function
REQ-014 SHALL, on key_valid=1 with count<4, set code <= {code[11:0], key_code} and count <= count+1 in the same edge.
REQ-015 SHALL ignore key_valid when count==4 (buffer full): code and count remain unchanged.
REQ-016 SHALL, when clr=1, set code=0 and count=0 on that edge; clr takes priority over a simultaneous key_valid.
REQ-017 SHALL run the prescaler from 0 to PRESCALE-1 and wrap to 0; the wrap cycle is the slot tick.
REQ-018 SHALL advance the scan index 0->1->2->3->0 on each slot tick; the 3->0 transition is the frame tick.
REQ-019 SHALL drive digit_sel = 1 << index.
REQ-020 SHALL drive digit_val = code[4*index+3 : 4*index].
REQ-021 SHALL derive digit_sel, digit_val and digit_en combinationally from registered state, with zero latency from state change to output.
REQ-022 SHALL drive digit_en = (index < count) AND NOT (blink AND blink_phase), so that unentered positions are blank.
REQ-023 SHALL use a blink-frame counter that counts frame ticks from 0 to BLINK_FRAMES-1, wraps, and toggles blink_phase on each wrap.
REQ-024 SHALL, while blink=0, hold the blink-frame counter and blink_phase at 0, so a blink period always starts with the display visible.
REQ-025 SHALL never stall scanning: key_valid, clr and blink do not affect the prescaler or the scan index.
REQ-026 SHALL keep digit_sel one-hot in every cycle, including the cycle immediately after reset.

Reset
REQ-027 SHALL, while rst_n=0, force the following asynchronously: code=0, count=0, prescaler=0, index=0, blink-frame counter=0, blink_phase=0.
REQ-028 SHALL present digit_sel=4'b0001, digit_en=0 and digit_val=0 during reset.
REQ-029 SHALL, on reset asserted mid-entry or mid-scan, discard all state; the first slot tick after release occurs PRESCALE cycles after the first active edge.

Structure
REQ-030 SHALL take the digit count (4) and digit width (4) as constants from the shared project defines include, not local literals.
REQ-031 SHALL place the prescaler plus frame divider in one sub-module, tick_gen, which outputs single-cycle slot_tick and frame_tick pulses.
REQ-032 SHALL keep the entry buffer and the output mux in disp_scan itself; the 7-segment decoding stays downstream.

Verification (PRESCALE=4, BLINK_FRAMES=2)
REQ-033 SHALL cover key entry: key strobes 1, 2, 3 -> code=16'h0123, count=3; digit_en=1 at index 0..2 and 0 at index 3; at index 2 the bench sees digit_val=1, digit_sel=4'b0100.
REQ-034 SHALL cover a full buffer: five strobes 1, 2, 3, 4, 5 -> code=16'h1234, count=4; the fifth strobe is ignored.
REQ-035 SHALL cover simultaneous clr and key_valid (key_code=7) -> code=0, count=0 on the next edge.
REQ-036 SHALL cover scan timing: after reset release, digit_sel=0001 for 4 cycles, then 0010, 0100, 1000, then back to 0001 at cycle 16.
REQ-037 SHALL cover blink: count=4, blink=1 -> digit_en=1 for 2 frames (32 cycles), 0 for 32, 1 for 32; dropping blink restores digit_en=1 on the next cycle.
REQ-038 SHALL cover reset mid-operation: rst_n pulsed low at index 2 with count=3 -> outputs go to reset values immediately, and after release code=0 and digit_sel=0001.

Source files
------------

// File: rtl/disp_scan_pkg.sv
// Shared constants and types for the multiplexed display scanner.
package disp_scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned CODE_W     = NUM_DIGITS * DIGIT_W;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_HIDDEN  = 1'b1
  } blink_phase_e;

  function automatic logic [NUM_DIGITS-1:0] onehot(input idx_t i);
    return NUM_DIGITS'(1) << i;
  endfunction

endpackage

// File: rtl/disp_scan_if.sv
// Key-entry inputs and display-drive outputs of disp_scan.
interface disp_scan_if;
  import disp_scan_pkg::*;

  logic                  key_valid;
  logic [DIGIT_W-1:0]    key_code;
  logic                  clr;
  logic                  blink;
  logic [DIGIT_W-1:0]    digit_val;
  logic                  digit_en;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic [CNT_W-1:0]      count;
  logic [CODE_W-1:0]     code;

  modport master (
    output key_valid, key_code, clr, blink,
    input  digit_val, digit_en, digit_sel, count, code
  );

  modport slave (
    input  key_valid, key_code, clr, blink,
    output digit_val, digit_en, digit_sel, count, code
  );

endinterface

// File: rtl/disp_scan_tick_gen.sv
// Slot prescaler and frame divider: single-cycle slot and frame pulses.
module tick_gen
  import disp_scan_pkg::*;
#(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_tick_o,
  output logic frame_tick_o
);

  localparam int unsigned PW = $clog2(PRESCALE);

  logic [PW-1:0] presc_q, presc_d;
  idx_t          slot_q,  slot_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      slot_q  <= '0;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    slot_tick_o  = (presc_q == PW'(PRESCALE - 1));
    frame_tick_o = slot_tick_o && (slot_q == idx_t'(NUM_DIGITS - 1));
    presc_d      = slot_tick_o ? '0 : presc_q + 1'b1;
    slot_d       = slot_tick_o ? slot_q + 1'b1 : slot_q;
  end

endmodule

// File: rtl/disp_scan.sv
// 4-digit key-entry buffer with time-multiplexed display scan and blink.
module disp_scan
  import disp_scan_pkg::*;
#(
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  disp_scan_if.slave bus
);

  localparam int unsigned BF_W = 8;

  logic              slot_tick, frame_tick;
  idx_t              index_q, index_d;
  logic [CODE_W-1:0] code_q,  code_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BF_W-1:0]   bcnt_q,  bcnt_d;
  blink_phase_e      phase_q, phase_d;
  logic              blanked;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .slot_tick_o  (slot_tick),
    .frame_tick_o (frame_tick)
  );

  // index_q mirrors the divider's slot count; both reset and advance together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= '0;
      code_q  <= '0;
      count_q <= '0;
      bcnt_q  <= '0;
      phase_q <= PH_VISIBLE;
    end else begin
      index_q <= index_d;
      code_q  <= code_d;
      count_q <= count_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    index_d = slot_tick ? index_q + 1'b1 : index_q;
    code_d  = code_q;
    count_d = count_q;
    if (bus.clr) begin
      code_d  = '0;
      count_d = '0;
    end else if (bus.key_valid && (count_q < CNT_W'(NUM_DIGITS))) begin
      code_d  = {code_q[CODE_W-DIGIT_W-1:0], bus.key_code};
      count_d = count_q + 1'b1;
    end
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!bus.blink) begin
      bcnt_d  = '0;
      phase_d = PH_VISIBLE;
    end else if (frame_tick) begin
      if (bcnt_q == BF_W'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    blanked = bus.blink && (phase_q == PH_HIDDEN);
  end

  always_comb begin
    bus.digit_val = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (index_q == idx_t'(i)) bus.digit_val = code_q[i*DIGIT_W +: DIGIT_W];
    end
    bus.digit_sel = onehot(index_q);
    bus.digit_en  = (CNT_W'(index_q) < count_q) && !blanked;
    bus.count     = count_q;
    bus.code      = code_q;
  end

endmodule

// File: tb/tb_disp_scan.sv
// Self-checking bench for disp_scan: vector table, directed corners, random vs model.
module tb_disp_scan;
  import disp_scan_pkg::*;

  localparam int P  = 4;
  localparam int BF = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  disp_scan_if bus ();

  disp_scan #(
    .PRESCALE     (P),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: elapsed edges since release, list of entered digits,
  // and frame ticks seen while blink has been held high.
  int          m_t;
  int unsigned m_q[$];
  int          m_nf;

  typedef struct {
    bit        kv;
    bit [3:0]  kc;
    bit        cl;
    bit [15:0] exp_code;
    bit [2:0]  exp_cnt;
  } vec_t;
  vec_t tbl[$];

  int exp_sel[17] = '{1,1,1,1, 2,2,2,2, 4,4,4,4, 8,8,8,8, 1};

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic int m_code();
    int c = 0;
    foreach (m_q[i]) c = (c << 4) | int'(m_q[i]);
    return c;
  endfunction

  function automatic int m_idx();
    return (m_t / P) % 4;
  endfunction

  function automatic int m_en();
    bit hidden = ((m_nf / BF) % 2) == 1;
    return ((m_idx() < m_q.size()) && !(bus.blink && hidden)) ? 1 : 0;
  endfunction

  task automatic check_all();
    chk("code",      int'(bus.code),      m_code());
    chk("count",     int'(bus.count),     m_q.size());
    chk("digit_sel", int'(bus.digit_sel), 1 << m_idx());
    chk("digit_val", int'(bus.digit_val), (m_code() >> (4 * m_idx())) & 15);
    chk("digit_en",  int'(bus.digit_en),  m_en());
  endtask

  task automatic cycle(input bit kv, input bit [3:0] kc, input bit cl, input bit bl);
    bit frame;
    bus.key_valid = kv;
    bus.key_code  = kc;
    bus.clr       = cl;
    bus.blink     = bl;
    @(posedge clk);
    frame = (m_t % (4 * P)) == (4 * P - 1);
    if (cl) m_q.delete();
    else if (kv && m_q.size() < 4) m_q.push_back(int'(kc));
    if (!bl) m_nf = 0;
    else if (frame) m_nf++;
    m_t++;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    bus.clr       = 1'b0;
    bus.blink     = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_sel",   int'(bus.digit_sel), 1);
    chk("rst_en",    int'(bus.digit_en),  0);
    chk("rst_val",   int'(bus.digit_val), 0);
    chk("rst_code",  int'(bus.code),      0);
    chk("rst_count", int'(bus.count),     0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_t  = 0;
    m_nf = 0;
    m_q.delete();
  endtask

  initial begin
    bit found;
    bit b;

    #2;
    do_reset();

    // Entry table: buffer fill, overflow, clr priority.
    tbl.push_back(vec_t'{1'b1, 4'h1, 1'b0, 16'h0001, 3'd1});
    tbl.push_back(vec_t'{1'b1, 4'h2, 1'b0, 16'h0012, 3'd2});
    tbl.push_back(vec_t'{1'b1, 4'h3, 1'b0, 16'h0123, 3'd3});
    tbl.push_back(vec_t'{1'b0, 4'h0, 1'b0, 16'h0123, 3'd3});
    tbl.push_back(vec_t'{1'b1, 4'h4, 1'b0, 16'h1234, 3'd4});
    tbl.push_back(vec_t'{1'b1, 4'h5, 1'b0, 16'h1234, 3'd4});
    tbl.push_back(vec_t'{1'b0, 4'h0, 1'b0, 16'h1234, 3'd4});
    tbl.push_back(vec_t'{1'b1, 4'h7, 1'b1, 16'h0000, 3'd0});
    tbl.push_back(vec_t'{1'b1, 4'h9, 1'b0, 16'h0009, 3'd1});
    tbl.push_back(vec_t'{1'b1, 4'hA, 1'b1, 16'h0000, 3'd0});
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].kv, tbl[i].kc, tbl[i].cl, 1'b0);
      chk("tbl_code",  int'(bus.code),  int'(tbl[i].exp_code));
      chk("tbl_count", int'(bus.count), int'(tbl[i].exp_cnt));
    end

    // Scan timing from reset release.
    do_reset();
    for (int c = 0; c < 17; c++) begin
      chk("scan_sel", int'(bus.digit_sel), exp_sel[c]);
      cycle(1'b0, 4'h0, 1'b0, 1'b0);
    end

    // Key entry 1,2,3 and per-position display.
    do_reset();
    cycle(1'b1, 4'h1, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    chk("k_code", int'(bus.code), 16'h0123);
    chk("k_cnt",  int'(bus.count), 3);
    found = 1'b0;
    for (int c = 0; c < 16; c++) begin
      cycle(1'b0, 4'h0, 1'b0, 1'b0);
      chk("k_en", int'(bus.digit_en), (m_idx() < 3) ? 1 : 0);
      if (m_idx() == 2 && !found) begin
        found = 1'b1;
        chk("k_sel2", int'(bus.digit_sel), 4'b0100);
        chk("k_val2", int'(bus.digit_val), 1);
      end
    end
    if (!found) timeout("k_idx2");

    // Blink: four digits, blink raised right after a frame boundary.
    do_reset();
    for (int k = 1; k <= 4; k++) cycle(1'b1, 4'(k), 1'b0, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 32 && !found; c++) begin
      if (m_t % 16 == 0) found = 1'b1;
      else cycle(1'b0, 4'h0, 1'b0, 1'b0);
    end
    if (!found) timeout("blink_sync");
    bus.blink = 1'b1;
    #1;
    chk("blink_en", int'(bus.digit_en), 1);
    for (int i = 1; i < 98; i++) begin
      cycle(1'b0, 4'h0, 1'b0, 1'b1);
      chk("blink_en", int'(bus.digit_en), (i < 32 || (i >= 64 && i < 96)) ? 1 : 0);
    end
    bus.blink = 1'b0;
    #1;
    chk("unblink_now", int'(bus.digit_en), 1);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    chk("unblink_next", int'(bus.digit_en), 1);

    // Reset asserted mid-scan with three digits entered.
    do_reset();
    cycle(1'b1, 4'h1, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 16 && !found; c++) begin
      if (m_idx() == 2) found = 1'b1;
      else cycle(1'b0, 4'h0, 1'b0, 1'b0);
    end
    if (!found) timeout("mid_sync");
    chk("mid_pre_sel", int'(bus.digit_sel), 4'b0100);
    do_reset();
    chk("mid_code", int'(bus.code), 0);
    chk("mid_sel",  int'(bus.digit_sel), 1);
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 4'h0, 1'b0, 1'b0);
      chk("mid_slot", int'(bus.digit_sel), (c < 3) ? 1 : 2);
    end

    // Random traffic against the model.
    do_reset();
    b = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) b = ~b;
      cycle($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 40) == 0, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
